// File: rtl/sar_pkg.sv
// Shared definitions for the parametrised SAR control logic: FSM states,
// comparator decode constants and default configuration values.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONV,
        DONE
    } sar_state_t;

    // {Op, Om} patterns that represent a resolved comparator decision.
    localparam logic [1:0] CMP_HI = 2'b10;
    localparam logic [1:0] CMP_LO = 2'b01;

    localparam int NBITS_DEF       = 8;
    localparam int SAMPLE_CYC_DEF  = 2;
    localparam int TIMEOUT_CYC_DEF = 4;

endpackage

// File: rtl/sar_cmp_decode.sv
// Comparator decode: Op/Om -> decision valid and bit value.
// With SAR_LOGIC_TIMEOUT_EN defined it also forces a 0 decision after TIMEOUT_CYC stalled cycles.
module sar_cmp_decode
    import sar_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
`ifdef SAR_LOGIC_TIMEOUT_EN
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic conv,
    output logic forced,
`endif
    input  logic op,
    input  logic om,
    output logic valid,
    output logic bit_val
);

    if (TIMEOUT_CYC < 1) begin : g_param_check
        $error("sar_cmp_decode: TIMEOUT_CYC must be at least 1");
    end

    logic [1:0] cmp;
    logic       raw_valid;

    assign cmp       = {op, om};
    assign raw_valid = (cmp == CMP_HI) || (cmp == CMP_LO);

`ifdef SAR_LOGIC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] stall_cnt;
    logic          expire;

    // The last allowed stalled cycle becomes the forced-zero decision itself.
    assign expire  = conv && !raw_valid && (stall_cnt == TW'(TIMEOUT_CYC - 1));
    assign valid   = raw_valid || expire;
    assign bit_val = raw_valid && (cmp == CMP_HI);
    assign forced  = expire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (en) begin
            if (conv && !raw_valid && !expire) begin
                stall_cnt <= stall_cnt + TW'(1);
            end else begin
                stall_cnt <= '0;
            end
        end
    end
`else
    assign valid   = raw_valid;
    assign bit_val = (cmp == CMP_HI);
`endif

endmodule

// File: rtl/sar_logic_param.sv
// Parametrised SAR ADC control: sample phase, NBITS binary-search decisions, B/BN DAC drive, result D.
// Optional comparator timeout (forced 0 decision, sticky err) enabled by defining SAR_LOGIC_TIMEOUT_EN.
module sar_logic_param
    import sar_pkg::*;
#(
    parameter int NBITS       = NBITS_DEF,
    parameter int SAMPLE_CYC  = SAMPLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             En,
    input  logic             start,
    input  logic             Op,
    input  logic             Om,
    output logic             smp,
    output logic [NBITS-2:0] B,
    output logic [NBITS-2:0] BN,
    output logic [NBITS-1:0] D,
    output logic             busy,
    output logic             done,
    output logic             err
);

    if (NBITS < 2 || NBITS > 16 || SAMPLE_CYC < 1) begin : g_param_check
        $error("sar_logic_param: NBITS must be 2..16 and SAMPLE_CYC at least 1");
    end

    localparam int KW = $clog2(NBITS);
    localparam int SW = $clog2(SAMPLE_CYC + 1);

    sar_state_t       state_q;
    logic [KW-1:0]    k_q;
    logic [SW-1:0]    scnt_q;
    logic [NBITS-1:1] res_q;
    logic [NBITS-1:0] d_q;
    logic [NBITS-2:0] b_q;
    logic [NBITS-2:0] bn_q;
    logic             smp_q;
    logic             busy_q;
    logic             done_q;
    logic             dec_valid;
    logic             dec_bit;

`ifdef SAR_LOGIC_TIMEOUT_EN
    logic in_conv;
    logic dec_forced;
    logic err_q;

    assign in_conv = (state_q == CONV);
`endif

    sar_cmp_decode #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_dec (
`ifdef SAR_LOGIC_TIMEOUT_EN
        .clk    (clk),
        .rst    (rst),
        .en     (En),
        .conv   (in_conv),
        .forced (dec_forced),
`endif
        .op     (Op),
        .om     (Om),
        .valid  (dec_valid),
        .bit_val(dec_bit)
    );

    // Whole datapath freezes while En is low; done therefore lasts one enabled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            scnt_q  <= '0;
            res_q   <= '0;
            d_q     <= '0;
            b_q     <= '0;
            bn_q    <= '0;
            smp_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (En) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SAMPLE;
                        smp_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        b_q     <= '0;
                        bn_q    <= '0;
                        res_q   <= '0;
                        k_q     <= '0;
                        scnt_q  <= '0;
                    end
                end
                SAMPLE: begin
                    if (scnt_q == SW'(SAMPLE_CYC - 1)) begin
                        state_q <= CONV;
                        smp_q   <= 1'b0;
                        k_q     <= KW'(NBITS - 1);
                    end else begin
                        scnt_q <= scnt_q + SW'(1);
                    end
                end
                CONV: begin
                    if (dec_valid) begin
                        // Bit k>=1 also drives DAC switch k-1; the LSB only lands in D.
                        for (int i = 1; i < NBITS; i++) begin
                            if (int'(k_q) == i) begin
                                res_q[i]    <= dec_bit;
                                b_q[i-1]    <= dec_bit;
                                bn_q[i-1]   <= ~dec_bit;
                            end
                        end
                        if (k_q == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            d_q     <= {res_q, dec_bit};
                        end else begin
                            k_q <= k_q - KW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SAR_LOGIC_TIMEOUT_EN
    // err describes the result in flight, so it restarts with each new sample phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (En) begin
            if (state_q == IDLE && start) begin
                err_q <= 1'b0;
            end else if (in_conv && dec_forced) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign smp  = smp_q;
    assign B    = b_q;
    assign BN   = bn_q;
    assign D    = d_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_sar_logic_param.sv
// Self-checking bench for sar_logic_param: randomized conversions against a conversion-level reference model.
// Timeout scenarios are exercised when SAR_LOGIC_TIMEOUT_EN is defined.
module tb_sar_logic_param;

    localparam int NBITS       = 8;
    localparam int SAMPLE_CYC  = 2;
    localparam int TIMEOUT_CYC = 4;
`ifdef SAR_LOGIC_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             En = 1'b0;
    logic             start = 1'b0;
    logic             Op = 1'b0;
    logic             Om = 1'b0;
    logic             smp;
    logic [NBITS-2:0] B;
    logic [NBITS-2:0] BN;
    logic [NBITS-1:0] D;
    logic             busy;
    logic             done;
    logic             err;

    int               vectors = 0;
    int               miscompares = 0;
    logic [NBITS-1:0] d_model = '0;
    logic             err_model = 1'b0;

    sar_logic_param #(
        .NBITS      (NBITS),
        .SAMPLE_CYC (SAMPLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .En   (En),
        .start(start),
        .Op   (Op),
        .Om   (Om),
        .smp  (smp),
        .B    (B),
        .BN   (BN),
        .D    (D),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    // One conversion; phase -1 accept, 0 sample, 1 decide, 2 done, 3 back in idle.
    task automatic run_conv(input logic [NBITS-1:0] bits, input int stall_bit, input int stall_len,
                            input bit en_rand, input string name);
        int               phase = -1;
        int               sleft = 0;
        int               k = 0;
        int               stalled = 0;
        int               en_edges = 0;
        int               done_edge = -1;
        int               cycles = 0;
        int               extra;
        bit               decided;
        logic             bitv;
        logic             same;
        logic [NBITS-1:0] rexp = '0;
        logic [NBITS-2:0] bexp = '0;
        logic [NBITS-2:0] bnexp = '0;
        extra = (stall_bit < 0) ? 0 :
                ((TMO && stall_len >= TIMEOUT_CYC) ? TIMEOUT_CYC - 1 : stall_len);
        while (phase != 3 && cycles < 300) begin
            if (phase == -1) begin
                En = 1'b1;
                start = 1'b1;
            end else begin
                En = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                start = 1'($urandom);
            end
            if (phase == 1 && k == stall_bit && stalled < stall_len) begin
                same = 1'($urandom);
                Op = same;
                Om = same;
            end else if (phase == 1) begin
                Op = bits[k];
                Om = ~bits[k];
            end else begin
                Op = 1'($urandom);
                Om = 1'($urandom);
            end
            @(posedge clk);
            cycles++;
            if (phase == -1) begin
                phase = 0;
                sleft = SAMPLE_CYC;
                k = NBITS - 1;
                err_model = 1'b0;
            end else if (En) begin
                en_edges++;
                case (phase)
                    0: begin
                        sleft--;
                        if (sleft == 0) phase = 1;
                    end
                    1: begin
                        decided = 1'b0;
                        bitv = Op;
                        if (Op != Om) begin
                            decided = 1'b1;
                        end else begin
                            stalled++;
                            if (TMO && stalled == TIMEOUT_CYC) begin
                                decided = 1'b1;
                                bitv = 1'b0;
                                err_model = 1'b1;
                            end
                        end
                        if (decided) begin
                            rexp[k] = bitv;
                            if (k >= 1) begin
                                bexp[k-1] = bitv;
                                bnexp[k-1] = ~bitv;
                            end
                            if (k == 0) begin
                                phase = 2;
                                d_model = rexp;
                                done_edge = en_edges;
                            end else begin
                                k--;
                            end
                        end
                    end
                    default: phase = 3;
                endcase
            end
            @(negedge clk);
            vectors += 5;
            if ({smp, busy, done} !== {phase == 0, phase == 0 || phase == 1, phase == 2}) begin
                miscompares++;
                $display("[TB] FAIL %s handshake cyc %0d: smp/busy/done got %b, expected %b", name, cycles,
                         {smp, busy, done}, {phase == 0, phase == 0 || phase == 1, phase == 2});
            end
            if (B !== bexp) begin
                miscompares++;
                $display("[TB] FAIL %s B cyc %0d: got %h, expected %h", name, cycles, B, bexp);
            end
            if (BN !== bnexp) begin
                miscompares++;
                $display("[TB] FAIL %s BN cyc %0d: got %h, expected %h", name, cycles, BN, bnexp);
            end
            if (D !== d_model) begin
                miscompares++;
                $display("[TB] FAIL %s D cyc %0d: got %h, expected %h", name, cycles, D, d_model);
            end
            if (err !== err_model) begin
                miscompares++;
                $display("[TB] FAIL %s err cyc %0d: got %b, expected %b", name, cycles, err, err_model);
            end
        end
        start = 1'b0;
        En = 1'b1;
        vectors++;
        if (phase != 3) begin
            miscompares++;
            $display("[TB] FAIL %s completion: still in phase %0d after %0d cycles, expected idle", name, phase, cycles);
        end
        vectors++;
        if (done_edge != SAMPLE_CYC + NBITS + extra) begin
            miscompares++;
            $display("[TB] FAIL %s latency: done after %0d enabled edges, expected %0d", name, done_edge,
                     SAMPLE_CYC + NBITS + extra);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        #1 rst = 1'b0;
        #2;
        vectors += 4;
        if ({smp, busy, done, err} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset flags: smp/busy/done/err got %b, expected 0000", {smp, busy, done, err});
        end
        if (B !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset B: got %h, expected 00", B);
        end
        if (BN !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset BN: got %h, expected 00", BN);
        end
        if (D !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset D: got %h, expected 00", D);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        $display("[TB] test_all_ones");
        run_conv(8'hFF, -1, 0, 1'b0, "all_ones");
        vectors++;
        if ({B, BN, D} !== {7'h7F, 7'h00, 8'hFF}) begin
            miscompares++;
            $display("[TB] FAIL all_ones final: B/BN/D got %h/%h/%h, expected 7f/00/ff", B, BN, D);
        end
    endtask

    task automatic test_all_zeros();
        $display("[TB] test_all_zeros");
        run_conv(8'h00, -1, 0, 1'b0, "all_zeros");
        vectors++;
        if ({B, BN, D, err} !== {7'h00, 7'h7F, 8'h00, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL all_zeros final: B/BN/D/err got %h/%h/%h/%b, expected 00/7f/00/0", B, BN, D, err);
        end
    endtask

    task automatic test_pattern();
        $display("[TB] test_pattern");
        run_conv(8'hA5, -1, 0, 1'b0, "pattern_a5");
        vectors++;
        if ({B, BN, D} !== {7'h52, 7'h2D, 8'hA5}) begin
            miscompares++;
            $display("[TB] FAIL pattern_a5 final: B/BN/D got %h/%h/%h, expected 52/2d/a5", B, BN, D);
        end
    endtask

    task automatic test_stall();
        $display("[TB] test_stall");
        run_conv(8'($urandom), 5, 3, 1'b0, "stall_bit5");
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        for (int n = 0; n < 8; n++) begin
            run_conv(8'($urandom), $urandom_range(0, NBITS - 1), $urandom_range(0, TMO ? 6 : 3), 1'b1, "random");
        end
    endtask

    task automatic test_reset_mid();
        $display("[TB] test_reset_mid");
        En = 1'b1;
        start = 1'b1;
        Op = 1'b1;
        Om = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (SAMPLE_CYC + 4) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({B, BN, busy, done} !== {7'h78, 7'h00, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_mid pre: B/BN/busy/done got %h/%h/%b/%b, expected 78/00/1/0", B, BN, busy, done);
        end
        #2 rst = 1'b0;
        #1;
        d_model = '0;
        err_model = 1'b0;
        vectors++;
        if ({smp, busy, done, err, B, BN, D} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid async: smp/busy/done/err/B/BN/D got %b%b%b%b/%h/%h/%h, expected all 0",
                     smp, busy, done, err, B, BN, D);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, D} !== {1'b0, 1'b0, 8'h00}) begin
                miscompares++;
                $display("[TB] FAIL reset_mid aborted: busy/done/D got %b/%b/%h, expected 0/0/00", busy, done, D);
            end
        end
        run_conv(8'($urandom), -1, 0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        $display("[TB] test_back_to_back");
        En = 1'b1;
        start = 1'b1;
        Op = 1'b1;
        Om = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done !== 1'b1 && cyc < 60);
        vectors++;
        if (cyc != SAMPLE_CYC + NBITS + 1) begin
            miscompares++;
            $display("[TB] FAIL b2b first done: cycle %0d, expected %0d", cyc, SAMPLE_CYC + NBITS + 1);
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done !== 1'b1 && cyc < 60);
        start = 1'b0;
        vectors++;
        if (cyc != 1 + SAMPLE_CYC + NBITS + 1) begin
            miscompares++;
            $display("[TB] FAIL b2b period: %0d cycles, expected %0d", cyc, 1 + SAMPLE_CYC + NBITS + 1);
        end
        vectors++;
        if (D !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL b2b D: got %h, expected ff", D);
        end
        d_model = 8'hFF;
        err_model = 1'b0;
        @(negedge clk);
    endtask

`ifdef SAR_LOGIC_TIMEOUT_EN
    task automatic test_timeout();
        $display("[TB] test_timeout");
        run_conv(8'hFF, 6, 10, 1'b0, "timeout_bit6");
        vectors++;
        if ({B, BN, D, err} !== {7'h5F, 7'h20, 8'hBF, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL timeout final: B/BN/D/err got %h/%h/%h/%b, expected 5f/20/bf/1", B, BN, D, err);
        end
        run_conv(8'($urandom), -1, 0, 1'b0, "timeout_clear");
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout err clear: got %b, expected 0", err);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_pattern();
        test_stall();
        test_random();
        test_reset_mid();
        test_back_to_back();
`ifdef SAR_LOGIC_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
